hazard_scheduler: RTL

Issue-stage scheduler between the instruction decoder and the execute pipeline. Accepts one 32-bit decoded control word per cycle over a valid/ready handshake. Holds the word back while a RAW/WAW register hazard, a multiplier structural hazard or a write-back port collision exists, and otherwise forwards it registered. Emits bubbles (all-zero control, `issue_valid`=0) when nothing issues, and counts stall cycles for performance monitoring.

---
 rtl/mips_ctrl_pkg.sv | 55 +++++
 rtl/reg_scoreboard.sv | 48 ++++
 rtl/hazard_scheduler.sv | 98 +++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// Control-word layout and decode helpers shared by the
// decoder and the issue-stage hazard scheduler.
package mips_ctrl_pkg;

    localparam int CW_W        = 32;
    localparam int CW_RS_HI    = 26;
    localparam int CW_RS_LO    = 22;
    localparam int CW_RT_HI    = 21;
    localparam int CW_RT_LO    = 17;
    localparam int CW_RD_HI    = 16;
    localparam int CW_RD_LO    = 12;
    localparam int CW_D_SEL    = 11;
    localparam int CW_C_SEL    = 10;
    localparam int CW_ALU_HI   = 9;
    localparam int CW_ALU_LO   = 8;
    localparam int CW_WR_RD    = 7;
    localparam int CW_WB_SEL   = 6;
    localparam int CW_WB_EN    = 5;
    localparam int CW_WB_REG_HI = 4;
    localparam int CW_WB_REG_LO = 0;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_sel_e;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] wb_reg;
        logic       writer;
        logic       mul;
        logic       rs_used;
        logic       rt_used;
    } ctrl_class_t;

    function automatic ctrl_class_t classify(input logic [CW_W-1:0] w);
        ctrl_class_t c;
        logic        en;
        logic        wr;
        en = w[CW_WB_EN];
        wr = w[CW_WR_RD];
        c.rs      = w[CW_RS_HI:CW_RS_LO];
        c.rt      = w[CW_RT_HI:CW_RT_LO];
        c.wb_reg  = w[CW_WB_REG_HI:CW_WB_REG_LO];
        c.writer  = en && (c.wb_reg != 5'd0);
        c.mul     = en && w[CW_D_SEL];
        c.rs_used = en || wr;
        c.rt_used = (en && !w[CW_C_SEL]) || wr;
        return c;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending counters for r1..r31; a counter holds the
// number of cycles a reader of that register must still wait.
module reg_scoreboard #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_set_en,
    input  logic [4:0]       i_set_reg,
    input  logic [CNT_W-1:0] i_set_lat,
    input  logic [4:0]       i_q0_reg,
    input  logic [4:0]       i_q1_reg,
    output logic             o_q0_pend,
    output logic             o_q1_pend,
    output logic             o_set_pend
);

    logic [CNT_W-1:0] r_cnt [1:31];
    logic [31:0]      w_pend;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < 32; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (i_set_en && (i_set_reg == 5'(i))) begin
                    r_cnt[i] <= i_set_lat;
                end else if (r_cnt[i] != '0) begin
                    r_cnt[i] <= r_cnt[i] - 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_pend = '0;
        for (int i = 1; i < 32; i++) begin
            w_pend[i] = (r_cnt[i] != '0);
        end
    end

    assign o_q0_pend  = w_pend[i_q0_reg];
    assign o_q1_pend  = w_pend[i_q1_reg];
    assign o_set_pend = w_pend[i_set_reg];

endmodule

// File: rtl/hazard_scheduler.sv
// Issue-stage scheduler: holds a decoded word while a RAW/WAW,
// multiplier or write-back-port hazard exists, else issues it.
module hazard_scheduler
    import mips_ctrl_pkg::*;
#(
    parameter int PIPE_DEPTH = 3,
    parameter int MUL_LAT    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [CW_W-1:0] ctrl_in,
    input  logic            ctrl_valid,
    output logic            ctrl_ready,
    output logic [CW_W-1:0] ctrl_out,
    output logic            issue_valid,
    output logic [15:0]     stall_cycles
);

    localparam int LAT_MUL = PIPE_DEPTH + MUL_LAT - 1;
    localparam int SLOT_W  = PIPE_DEPTH + MUL_LAT + 1;
    localparam int CNT_W   = $clog2(SLOT_W);
    localparam int MB_W    = $clog2(MUL_LAT + 1);

    ctrl_class_t       w_cls;
    logic [CNT_W-1:0]  w_lat;
    logic              w_rs_pend;
    logic              w_rt_pend;
    logic              w_wb_pend;
    logic              w_hazard;
    logic              w_accept;
    logic [SLOT_W-1:0] w_slot_nxt;

    logic [SLOT_W-1:0] r_wb_slot;
    logic [MB_W-1:0]   r_mul_busy;
    logic [CW_W-1:0]   r_ctrl_out;
    logic              r_issue_valid;
    logic [15:0]       r_stall;

    assign w_cls = classify(ctrl_in);
    assign w_lat = w_cls.mul ? CNT_W'(LAT_MUL) : CNT_W'(PIPE_DEPTH);

    reg_scoreboard #(.CNT_W(CNT_W)) u_sb (
        .clk        (clk),
        .rst        (rst),
        .i_set_en   (w_accept && w_cls.writer),
        .i_set_reg  (w_cls.wb_reg),
        .i_set_lat  (w_lat - 1'b1),
        .i_q0_reg   (w_cls.rs),
        .i_q1_reg   (w_cls.rt),
        .o_q0_pend  (w_rs_pend),
        .o_q1_pend  (w_rt_pend),
        .o_set_pend (w_wb_pend)
    );

    assign w_hazard = (w_cls.rs_used && w_rs_pend)
                    || (w_cls.rt_used && w_rt_pend)
                    || (w_cls.writer && w_wb_pend)
                    || (w_cls.mul && (r_mul_busy != '0))
                    || (w_cls.writer && r_wb_slot[w_lat]);

    assign ctrl_ready = !w_hazard;
    assign w_accept   = ctrl_valid && ctrl_ready && !rst;

    // bit k set: a register write lands k cycles from now
    always_comb begin
        w_slot_nxt = r_wb_slot >> 1;
        if (w_accept && w_cls.writer) begin
            w_slot_nxt[w_lat - 1'b1] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb_slot     <= '0;
            r_mul_busy    <= '0;
            r_ctrl_out    <= '0;
            r_issue_valid <= 1'b0;
            r_stall       <= '0;
        end else begin
            r_wb_slot     <= w_slot_nxt;
            r_issue_valid <= w_accept;
            r_ctrl_out    <= w_accept ? ctrl_in : '0;
            if (w_accept && w_cls.mul) begin
                r_mul_busy <= MB_W'(MUL_LAT - 1);
            end else if (r_mul_busy != '0) begin
                r_mul_busy <= r_mul_busy - 1'b1;
            end
            if (ctrl_valid && !ctrl_ready && (r_stall != 16'hFFFF)) begin
                r_stall <= r_stall + 16'd1;
            end
        end
    end

    assign ctrl_out     = r_ctrl_out;
    assign issue_valid  = r_issue_valid;
    assign stall_cycles = r_stall;

endmodule
